// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package mem_ctrl_pkg;

  // Controller states: wait for a memory op, talk to memory, hand result to MEM/WB, or stop on timeout.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } state_e;

  // Default number of ACCESS cycles allowed before dmem_ready must arrive.
  localparam int TIMEOUT_CYCLES_DEF = 16;

  // Wait-counter width for the default timeout.
  localparam int CNT_W_DEF = $clog2(TIMEOUT_CYCLES_DEF);

  // Counter width for an arbitrary limit; never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side and memory-side signals of the access controller as one bundle.
interface mem_access_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  // EX/MEM slot
  logic          ex_valid;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          flush;
  logic [AW-1:0] ex_addr;
  logic [DW-1:0] ex_wdata;

  // Data memory port
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ready;
  logic [DW-1:0] dmem_rdata;

  // Pipeline control and results
  logic          stall;
  logic          wb_bubble;
  logic [DW-1:0] rdata;
  logic          timeout_err;

  // The controller side
  modport master (
    input  ex_valid, ex_mem_read, ex_mem_write, flush, ex_addr, ex_wdata,
    input  dmem_ready, dmem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output stall, wb_bubble, rdata, timeout_err
  );

  // The pipeline/memory environment side
  modport slave (
    output ex_valid, ex_mem_read, ex_mem_write, flush, ex_addr, ex_wdata,
    output dmem_ready, dmem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  stall, wb_bubble, rdata, timeout_err
  );

endinterface

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// Saturating wait counter; flags when the ACCESS wait budget is used up.
module mem_timeout_cnt
  import mem_ctrl_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int            W   = cnt_width(LIMIT);
  localparam logic [W-1:0]  MAX = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and stick at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == MAX);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: holds the pipeline while a load/store waits on a
// variable-latency data memory, and parks in ERR if memory never answers.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_ctrl_if.master bus
);

  state_e        state_q;
  logic          req_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;

  logic          mem_op;
  logic          start;
  logic          expired;
  logic          hold_d;

  // A squashed or non-memory instruction never starts an access
  assign mem_op = bus.ex_valid & ~bus.flush & (bus.ex_mem_read | bus.ex_mem_write);
  assign start  = (state_q == IDLE) & mem_op;

  mem_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start),
    .inc     ((state_q == ACCESS) & ~bus.dmem_ready),
    .expired (expired)
  );

  // Main FSM: latch the request on start, finish on ready, give up on expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mem_op) begin
            addr_q  <= bus.ex_addr;
            wdata_q <= bus.ex_wdata;
            // read+write together is treated as a store
            we_q    <= bus.ex_mem_write;
            req_q   <= 1'b1;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          // completion takes priority over an expiring counter
          if (bus.dmem_ready) begin
            req_q   <= 1'b0;
            if (!we_q) begin
              rdata_q <= bus.dmem_rdata;
            end
            state_q <= DONE;
          end else if (expired) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ERR;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        ERR: begin
          state_q <= ERR;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Pipeline hold: immediate on a starting op, kept through ACCESS and ERR, released in reset
  always_comb begin
    hold_d = 1'b0;
    if (rst_n) begin
      hold_d = start | (state_q == ACCESS) | (state_q == ERR);
    end
  end

  assign bus.stall       = hold_d;
  assign bus.wb_bubble   = hold_d;
  assign bus.dmem_req    = req_q;
  assign bus.dmem_we     = we_q;
  assign bus.dmem_addr   = addr_q;
  assign bus.dmem_wdata  = wdata_q;
  assign bus.rdata       = rdata_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: each op is described by (kind, address,
// data, ready delay) and the expected outputs come from the op's timeline.
module tb_mem_access_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  mem_access_ctrl #(
    .AW             (AW),
    .DW             (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int req_cycles  = 0;
  int stall_cycles = 0;

  bit          chk_en = 1'b0;
  logic        exp_stall, exp_bubble, exp_req, exp_we, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;

  task automatic cmp_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the timeline model, sampled mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_bit("stall", bus.stall, exp_stall);
      cmp_bit("wb_bubble", bus.wb_bubble, exp_bubble);
      cmp_bit("dmem_req", bus.dmem_req, exp_req);
      cmp_bit("timeout_err", bus.timeout_err, exp_err);
      cmp_word("rdata", bus.rdata, exp_rdata);
      if (exp_req) begin
        cmp_bit("dmem_we", bus.dmem_we, exp_we);
        cmp_word("dmem_addr", bus.dmem_addr, exp_addr);
        cmp_word("dmem_wdata", bus.dmem_wdata, exp_wdata);
      end
    end
    if (bus.dmem_req === 1'b1) req_cycles++;
    if (bus.stall === 1'b1) stall_cycles++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic fl,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic rdy, input logic [31:0] rdat);
    bus.ex_valid     = v;
    bus.ex_mem_read  = rd;
    bus.ex_mem_write = wr;
    bus.flush        = fl;
    bus.ex_addr      = a;
    bus.ex_wdata     = d;
    bus.dmem_ready   = rdy;
    bus.dmem_rdata   = rdat;
  endtask

  task automatic expect_quiet();
    exp_stall  = 1'b0;
    exp_bubble = 1'b0;
    exp_req    = 1'b0;
  endtask

  // One memory op: IDLE cycle, ACCESS cycles until ready (on ACCESS cycle
  // wait_n+1) or until the budget of TO cycles runs out, then DONE or ERR.
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rval,
                        input int wait_n, input bit flush_mid);
    bit finished = 1'b0;
    req_cycles   = 0;
    stall_cycles = 0;
    // IDLE: request seen, pipeline held at once
    drive(1'b1, rd, wr, 1'b0, addr, wdata, 1'b0, 32'h0);
    exp_stall = 1'b1; exp_bubble = 1'b1; exp_req = 1'b0;
    tick();
    exp_we = wr; exp_addr = addr; exp_wdata = wdata;
    for (int k = 1; k <= TO; k++) begin
      finished = (k == wait_n + 1);
      drive(1'b1, rd, wr, flush_mid && (k <= 2), ~addr, ~wdata, finished,
            finished ? rval : ~rval);
      exp_stall = 1'b1; exp_bubble = 1'b1; exp_req = 1'b1;
      tick();
      if (finished) break;
    end
    if (finished) begin
      // DONE: result handed over, pipeline released
      drive(1'b1, rd, wr, 1'b0, addr, wdata, 1'b0, 32'h0);
      expect_quiet();
      if (!wr) exp_rdata = rval;
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      tick();
      $display("op rd=%0b wr=%0b addr=%h wait=%0d completed rdata=%h", rd, wr, addr, wait_n, bus.rdata);
    end else begin
      // ERR: terminal, late ready and new ops change nothing
      exp_err = 1'b1; exp_stall = 1'b1; exp_bubble = 1'b1; exp_req = 1'b0;
      for (int e = 0; e < 3; e++) begin
        drive(1'b1, rd, wr, 1'b0, addr, wdata, (e == 0), rval);
        tick();
      end
      $display("op rd=%0b wr=%0b addr=%h timed out", rd, wr, addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    expect_quiet();
    exp_we = 1'b0; exp_addr = 32'h0; exp_wdata = 32'h0; exp_rdata = 32'h0; exp_err = 1'b0;
    #1 chk_en = 1'b1;
    tick();
    // op present while reset is held: still no stall
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'h0);
    tick();
    cmp_bit("rst_stall", bus.stall, 1'b0);
    cmp_bit("rst_dmem_we", bus.dmem_we, 1'b0);
    cmp_word("rst_dmem_addr", bus.dmem_addr, 32'h0);
    cmp_word("rst_dmem_wdata", bus.dmem_wdata, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;
    tick();
    $display("reset checked");

    // Non-memory instruction passes with no hold
    req_cycles = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'h99, 1'b0, 32'h0);
    repeat (3) tick();
    cmp_word("nonmem_req_cycles", 32'(req_cycles), 32'd0);
    $display("non-memory op checked");

    // Load, immediate ready
    run_op(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    cmp_word("load_rdata", bus.rdata, 32'hDEAD_BEEF);
    cmp_word("load_stall_cycles", 32'(stall_cycles), 32'd2);
    cmp_word("load_req_cycles", 32'(req_cycles), 32'd1);

    // Store, four wait cycles
    run_op(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'h5555_AAAA, 4, 1'b0);
    cmp_word("store_req_cycles", 32'(req_cycles), 32'd5);
    cmp_word("store_rdata_kept", bus.rdata, 32'hDEAD_BEEF);

    // Read and write together behave as a store
    run_op(1'b1, 1'b1, 32'h0000_0200, 32'hA5A5_5A5A, 32'h1111_1111, 1, 1'b0);
    cmp_word("rw_rdata_kept", bus.rdata, 32'hDEAD_BEEF);

    // Flush during ACCESS is ignored
    run_op(1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'hCAFE_F00D, 2, 1'b1);
    cmp_word("flushmid_rdata", bus.rdata, 32'hCAFE_F00D);
    cmp_word("flushmid_req_cycles", 32'(req_cycles), 32'd3);

    // Ready on the last allowed ACCESS cycle still completes
    run_op(1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'h0BAD_CAFE, TO - 1, 1'b0);
    cmp_word("edge_req_cycles", 32'(req_cycles), 32'd16);
    cmp_bit("edge_no_err", bus.timeout_err, 1'b0);

    // Flush in IDLE blocks the access
    req_cycles = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'h0, 1'b0, 32'h0);
    expect_quiet();
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    cmp_word("flushidle_req_cycles", 32'(req_cycles), 32'd0);
    $display("flush in IDLE checked");

    // Reset pulsed in the middle of an access
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0500, 32'h0, 1'b0, 32'h0);
    exp_stall = 1'b1; exp_bubble = 1'b1; exp_req = 1'b0;
    tick();
    exp_we = 1'b0; exp_addr = 32'h0000_0500; exp_wdata = 32'h0; exp_req = 1'b1;
    tick();
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    cmp_bit("midrst_req", bus.dmem_req, 1'b0);
    cmp_bit("midrst_stall", bus.stall, 1'b0);
    cmp_bit("midrst_bubble", bus.wb_bubble, 1'b0);
    cmp_word("midrst_rdata", bus.rdata, 32'h0);
    cmp_word("midrst_addr", bus.dmem_addr, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h7777_7777);
    expect_quiet();
    exp_rdata = 32'h0;
    exp_err   = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    req_cycles = 0;
    repeat (3) tick();
    cmp_word("postrst_req_cycles", 32'(req_cycles), 32'd0);
    $display("reset during ACCESS checked");

    // Memory never answers
    run_op(1'b1, 1'b0, 32'h0000_0600, 32'h0, 32'h3333_3333, 1000, 1'b0);
    cmp_word("timeout_req_cycles", 32'(req_cycles), 32'd16);
    cmp_bit("timeout_err_set", bus.timeout_err, 1'b1);
    cmp_bit("timeout_stall", bus.stall, 1'b1);

    // Reset leaves ERR
    chk_en = 1'b0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    cmp_bit("errrst_err", bus.timeout_err, 1'b0);
    cmp_bit("errrst_stall", bus.stall, 1'b0);
    tick();
    rst_n = 1'b1;
    expect_quiet();
    exp_err = 1'b0;
    chk_en = 1'b1;
    repeat (2) tick();
    chk_en = 1'b0;
    $display("reset out of ERR checked");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be: AW, default 32, address width; DW, default 32, data width; TIMEOUT_CYCLES, default 16, maximum wait for dmem_ready.
REQ-002 Ports SHALL be:
- clk, in, 1: single clock, all state on rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- ex_valid, in, 1: EX/MEM slot holds a valid instruction.
- ex_mem_read, in, 1: instruction loads.
- ex_mem_write, in, 1: instruction stores.
- flush, in, 1: squash the instruction in the EX/MEM slot.
- ex_addr, in, AW: effective address.
- ex_wdata, in, DW: store data.
- dmem_req, out, 1: memory request.
- dmem_we, out, 1: request is a write.
- dmem_addr, out, AW: request address.
- dmem_wdata, out, DW: request write data.
- dmem_ready, in, 1: memory accepts or completes the request.
- dmem_rdata, in, DW: read data, valid while dmem_ready is high.
- stall, out, 1: freezes PC, IF/ID, ID/EX and EX/MEM.
- wb_bubble, out, 1: forces MEM/WB control_wb_in to 2'b00.
- rdata, out, DW: captured load data to MEM/WB Read_data_in.
- timeout_err, out, 1: sticky memory-timeout flag.

Function
REQ-003 FSM states SHALL be IDLE, ACCESS, DONE and ERR.
REQ-004 A memory op SHALL mean ex_valid & ~flush & (ex_mem_read | ex_mem_write).
REQ-005 In IDLE with no memory op, outputs SHALL be stall=0 and wb_bubble=0. Non-memory instructions pass with zero added latency.
REQ-006 In IDLE with a memory op:
- stall=1 combinationally.
- wb_bubble=1.
- The request (addr, wdata, we) is latched.
- Next state is ACCESS.
REQ-007 If ex_mem_read and ex_mem_write are both high, the op SHALL be a write (dmem_we=1).
REQ-008 In ACCESS:
- dmem_req=1, with dmem_addr, dmem_wdata and dmem_we driven from the latched registers and stable until dmem_ready.
- stall=1 and wb_bubble=1.
REQ-009 In ACCESS with dmem_ready=1:
- rdata is captured from dmem_rdata (reads only; rdata holds its value on writes).
- dmem_req deasserts next cycle.
- Next state is DONE.
REQ-010 DONE SHALL last exactly one cycle:
- stall=0 and wb_bubble=0, so MEM/WB captures the result.
- rdata is valid.
- Next state is IDLE.
REQ-011 Minimum memory-op latency SHALL be 3 cycles (IDLE, ACCESS with immediate ready, DONE). Each extra cycle of dmem_ready=0 SHALL add one cycle.
REQ-012 The wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without dmem_ready. It SHALL saturate, never wrap.
REQ-013 When the counter reaches TIMEOUT_CYCLES-1 with dmem_ready=0, the next state SHALL be ERR.
REQ-014 If dmem_ready arrives in the same cycle the counter hits its limit, completion SHALL win and the next state SHALL be DONE.
REQ-015 ERR SHALL be terminal until reset, with dmem_req=0, stall=1, wb_bubble=1 and timeout_err=1.
REQ-016 flush SHALL only block starting an access from IDLE. flush during ACCESS SHALL be ignored and the access completes.
REQ-017 dmem_req SHALL never be asserted outside ACCESS.

Reset
REQ-018 On rst_n low, asynchronously:
- State is IDLE and the counter is 0.
- dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
- rdata=0 and timeout_err=0.
- stall=0 and wb_bubble=0.
REQ-019 Reset asserted mid-ACCESS SHALL drop dmem_req immediately. No completion SHALL be reported after reset release.

Structure
REQ-020 The state enum, TIMEOUT_CYCLES default and counter width ($clog2(TIMEOUT_CYCLES)) SHALL live in package mem_ctrl_pkg.
REQ-021 The wait counter SHALL be the sub-module mem_timeout_cnt, with inputs clr and inc and output expired.

Verification
REQ-022 Non-memory op (ex_valid=1, read=write=0) -> stall=0, wb_bubble=0, dmem_req never asserted.
REQ-023 Load at addr 0x0000_0040 with dmem_ready high on the first ACCESS cycle, rdata_in 0xDEAD_BEEF -> stall high for 2 cycles, DONE on cycle 3, rdata=0xDEAD_BEEF, wb_bubble=0 in DONE.
REQ-024 Store at addr 0x100, data 0x1234_5678, with ready after 4 wait cycles -> dmem_req, dmem_we=1 and stable addr/data for 5 ACCESS cycles, then DONE, rdata unchanged.
REQ-025 TIMEOUT_CYCLES=16 with dmem_ready held low -> ERR after 16 ACCESS cycles, timeout_err=1, stall stays 1; a second case with ready on cycle 16 -> DONE, no error.
REQ-026 flush=1 with a load in IDLE -> no request, stall=0; flush asserted mid-ACCESS -> access still completes.
REQ-027 rst_n pulsed low during ACCESS -> dmem_req and stall drop in the same cycle, all outputs at reset values, FSM in IDLE.
